// File: rtl/noc_flit_receiver_if.sv
// Output flit stream of the NoC receiver: valid/ready with tdata/tdest/tlast.
// The receiver drives through master; the downstream consumer uses slave.
interface noc_flit_receiver_if #(
  parameter int FLIT_WIDTH = 32,
  parameter int DEST_WIDTH = 6
);
  logic                  m_tvalid;
  logic                  m_tready;
  logic [FLIT_WIDTH-1:0] m_tdata;
  logic [DEST_WIDTH-1:0] m_tdest;
  logic                  m_tlast;

  modport master (output m_tvalid, m_tdata, m_tdest, m_tlast, input m_tready);
  modport slave  (input m_tvalid, m_tdata, m_tdest, m_tlast, output m_tready);
endinterface

// File: rtl/noc_flit_receiver.sv
// Credit-link sink: buffers flits in a show-ahead FIFO (1-cycle latency), stalls on m_tready, drops when full and flags overflow.
// Returns one registered credit per pop. Optional NOC_RX_PKT_CHECK_EN adds a push-side packet FSM that flags dest changes.
module noc_flit_receiver #(
  parameter int FLIT_WIDTH        = 32,
  parameter int DEST_WIDTH        = 6,
  parameter int FLIT_BUFFER_DEPTH = 8,
  parameter int PKT_CNT_WIDTH     = 16
) (
  input  logic                     clk_noc,
  input  logic                     rst_n,
  input  logic [FLIT_WIDTH-1:0]    data_in,
  input  logic [DEST_WIDTH-1:0]    dest_in,
  input  logic                     is_tail_in,
  input  logic                     send_in,
  output logic                     credit_out,
  output logic [PKT_CNT_WIDTH-1:0] pkt_count,
  output logic                     overflow_err,
  output logic                     dest_err,
  noc_flit_receiver_if.master      m_axis
);
  localparam int PTR_W = $clog2(FLIT_BUFFER_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FLIT_BUFFER_DEPTH);

  typedef struct packed {
    logic [FLIT_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0] dest;
    logic                  tail;
  } flit_t;

  flit_t                    mem_q [FLIT_BUFFER_DEPTH];
  flit_t                    head, wr_flit;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]           count_q, count_d;
  logic                     credit_q, credit_d;
  logic [PKT_CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
  logic                     ovf_q, ovf_d;
  logic                     vld, full, pop, push, drop;

  always_comb begin
    head     = mem_q[rd_ptr_q];
    wr_flit  = '{data: data_in, dest: dest_in, tail: is_tail_in};
    vld      = (count_q != '0);
    full     = (count_q == FULL_CNT);
    pop      = vld && m_axis.m_tready;
    // When full, a same-edge pop frees the slot the push lands in.
    push     = send_in && (!full || pop);
    drop     = send_in && full && !pop;
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    credit_d = pop;
    pkt_cnt_d = pkt_cnt_q + PKT_CNT_WIDTH'(pop && head.tail);
    ovf_d    = ovf_q | drop;
  end

  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      credit_q  <= 1'b0;
      pkt_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      credit_q  <= credit_d;
      pkt_cnt_q <= pkt_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge clk_noc) begin
    if (push) mem_q[wr_ptr_q] <= wr_flit;
  end

  // Storage is not reset; outputs are zeroed whenever nothing is valid.
  assign m_axis.m_tvalid = vld;
  assign m_axis.m_tdata  = vld ? head.data : '0;
  assign m_axis.m_tdest  = vld ? head.dest : '0;
  assign m_axis.m_tlast  = vld ? head.tail : 1'b0;
  assign credit_out      = credit_q;
  assign pkt_count       = pkt_cnt_q;
  assign overflow_err    = ovf_q;

`ifdef NOC_RX_PKT_CHECK_EN
  typedef enum logic {S_IDLE, S_IN_PKT} state_t;

  state_t                st_q, st_d;
  logic [DEST_WIDTH-1:0] dest_lat_q, dest_lat_d;
  logic                  derr_q, derr_d;

  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= S_IDLE;
      dest_lat_q <= '0;
      derr_q     <= 1'b0;
    end else begin
      st_q       <= st_d;
      dest_lat_q <= dest_lat_d;
      derr_q     <= derr_d;
    end
  end

  // Only accepted flits advance the packet tracker; dropped ones are ignored.
  always_comb begin
    st_d = st_q;
    case (st_q)
      S_IDLE:   if (push && !is_tail_in) st_d = S_IN_PKT;
      S_IN_PKT: if (push && is_tail_in)  st_d = S_IDLE;
      default:  st_d = S_IDLE;
    endcase
  end

  always_comb begin
    dest_lat_d = dest_lat_q;
    derr_d     = derr_q;
    if (st_q == S_IDLE && push && !is_tail_in) dest_lat_d = dest_in;
    if (st_q == S_IN_PKT && push && (dest_in != dest_lat_q)) derr_d = 1'b1;
  end

  assign dest_err = derr_q;
`else
  assign dest_err = 1'b0;
`endif
endmodule

// File: tb/tb_noc_flit_receiver.sv
// Scoreboard bench for noc_flit_receiver: expected flits queued at send, checked at each output handshake.
module tb_noc_flit_receiver;
  logic        clk_noc = 1'b0;
  logic        rst_n   = 1'b0;
  logic [31:0] data_in = '0;
  logic [5:0]  dest_in = '0;
  logic        is_tail_in = 1'b0;
  logic        send_in = 1'b0;
  logic        credit_out;
  logic [15:0] pkt_count;
  logic        overflow_err;
  logic        dest_err;

  int vectors     = 0;
  int miscompares = 0;
  int cred_cnt    = 0;
  bit hs_prev     = 1'b0;

  typedef struct {
    logic [31:0] d;
    logic [5:0]  dest;
    logic        last;
  } exp_t;
  exp_t sb[$];

  noc_flit_receiver_if #(.FLIT_WIDTH(32), .DEST_WIDTH(6)) m_if ();

  noc_flit_receiver #(
    .FLIT_WIDTH(32), .DEST_WIDTH(6), .FLIT_BUFFER_DEPTH(8), .PKT_CNT_WIDTH(16)
  ) dut (
    .clk_noc(clk_noc), .rst_n(rst_n),
    .data_in(data_in), .dest_in(dest_in), .is_tail_in(is_tail_in), .send_in(send_in),
    .credit_out(credit_out), .pkt_count(pkt_count),
    .overflow_err(overflow_err), .dest_err(dest_err),
    .m_axis(m_if.master)
  );

  always #5 clk_noc = ~clk_noc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: credit must trail each handshake by exactly one cycle.
  always @(negedge clk_noc) begin
    exp_t e;
    bit   hs;
    if (!rst_n) begin
      hs_prev = 1'b0;
    end else begin
      chk("credit_timing", 64'(credit_out), 64'(hs_prev));
      if (credit_out) cred_cnt++;
      hs = m_if.m_tvalid && m_if.m_tready;
      if (hs) begin
        if (sb.size() == 0) begin
          chk("spurious_flit", 64'(m_if.m_tdata), 64'hDEAD_BEEF_0000_0000);
        end else begin
          e = sb.pop_front();
          chk("out_data", 64'(m_if.m_tdata), 64'(e.d));
          chk("out_dest", 64'(m_if.m_tdest), 64'(e.dest));
          chk("out_last", 64'(m_if.m_tlast), 64'(e.last));
        end
      end
      hs_prev = hs;
    end
  end

  task automatic send(input logic [31:0] d, input logic [5:0] de, input logic t, input bit keep);
    data_in    = d;
    dest_in    = de;
    is_tail_in = t;
    send_in    = 1'b1;
    if (keep) sb.push_back('{d: d, dest: de, last: t});
    @(posedge clk_noc); #1;
    send_in = 1'b0;
  endtask

  task automatic drain();
    m_if.m_tready = 1'b1;
    for (int i = 0; i < 64 && sb.size() != 0; i++) @(posedge clk_noc);
    #1;
    repeat (2) @(posedge clk_noc);
    #1;
    chk("drain_empty", 64'(sb.size()), 64'd0);
    chk("drain_tvalid", 64'(m_if.m_tvalid), 64'd0);
  endtask

  task automatic do_reset();
    m_if.m_tready = 1'b0;
    send_in = 1'b0;
    @(posedge clk_noc); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk_noc);
    #1;
    rst_n = 1'b1;
    sb.delete();
    cred_cnt = 0;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_if.m_tready = 1'b0;
    repeat (2) @(posedge clk_noc);
    #1;
    chk("rst_tvalid", 64'(m_if.m_tvalid), 64'd0);
    chk("rst_tdata", 64'(m_if.m_tdata), 64'd0);
    chk("rst_tdest", 64'(m_if.m_tdest), 64'd0);
    chk("rst_tlast", 64'(m_if.m_tlast), 64'd0);
    chk("rst_credit", 64'(credit_out), 64'd0);
    chk("rst_pkt", 64'(pkt_count), 64'd0);
    chk("rst_ovf", 64'(overflow_err), 64'd0);
    chk("rst_derr", 64'(dest_err), 64'd0);
    rst_n = 1'b1;

    // 1: three-flit packet, one flit at a time
    cred_cnt = 0;
    m_if.m_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(32'hA0 + 32'(i), 6'h05, (i == 2), 1'b1);
      chk("t1_lat_vld", 64'(m_if.m_tvalid), 64'd1);
      chk("t1_lat_dat", 64'(m_if.m_tdata), 64'(32'hA0 + 32'(i)));
      chk("t1_lat_last", 64'(m_if.m_tlast), 64'(i == 2));
      @(posedge clk_noc); #1;
    end
    drain();
    chk("t1_credits", 64'(cred_cnt), 64'd3);
    chk("t1_pkt", 64'(pkt_count), 64'd1);

    // 2: fill while stalled, then drain back-to-back
    cred_cnt = 0;
    m_if.m_tready = 1'b0;
    for (int i = 0; i < 8; i++) send(32'hB000_0000 + 32'(i), 6'h05, 1'b0, 1'b1);
    repeat (3) @(posedge clk_noc);
    #1;
    chk("t2_no_credit", 64'(cred_cnt), 64'd0);
    chk("t2_hold_vld", 64'(m_if.m_tvalid), 64'd1);
    chk("t2_hold_dat", 64'(m_if.m_tdata), 64'hB000_0000);
    m_if.m_tready = 1'b1;
    repeat (8) @(posedge clk_noc);
    #1;
    chk("t2_8cyc", 64'(sb.size()), 64'd0);
    drain();
    chk("t2_credits", 64'(cred_cnt), 64'd8);

    // 3: overflow while full and stalled
    cred_cnt = 0;
    m_if.m_tready = 1'b0;
    for (int i = 0; i < 8; i++) send(32'hC000_0000 + 32'(i), 6'h05, 1'b0, 1'b1);
    chk("t3_ovf_pre", 64'(overflow_err), 64'd0);
    send(32'hC000_0009, 6'h05, 1'b0, 1'b0);
    chk("t3_ovf", 64'(overflow_err), 64'd1);
    drain();
    chk("t3_credits", 64'(cred_cnt), 64'd8);
    chk("t3_ovf_sticky", 64'(overflow_err), 64'd1);

    // 4: full with simultaneous push and pop
    do_reset();
    chk("t4_ovf_rst", 64'(overflow_err), 64'd0);
    for (int i = 0; i < 8; i++) send(32'hD000_0000 + 32'(i), 6'h05, 1'b0, 1'b1);
    m_if.m_tready = 1'b1;
    send(32'hD000_0008, 6'h05, 1'b0, 1'b1);
    m_if.m_tready = 1'b0;
    chk("t4_ovf", 64'(overflow_err), 64'd0);
    @(posedge clk_noc); #1;
    chk("t4_one_credit", 64'(cred_cnt), 64'd1);
    send(32'hD000_00FF, 6'h05, 1'b0, 1'b0);
    chk("t4_still_full", 64'(overflow_err), 64'd1);
    drain();
    chk("t4_credits", 64'(cred_cnt), 64'd9);

    // 5: packet counter wrap
    do_reset();
    m_if.m_tready = 1'b1;
    for (int i = 0; i < 65535; i++) send(32'(i), 6'(i), 1'b1, 1'b1);
    drain();
    chk("t5_pkt_max", 64'(pkt_count), 64'hFFFF);
    send(32'h5555_AAAA, 6'h2A, 1'b1, 1'b1);
    drain();
    chk("t5_pkt_wrap", 64'(pkt_count), 64'd0);

    // 6: destination change inside a packet
    chk("t6_derr_pre", 64'(dest_err), 64'd0);
    send(32'hE0, 6'h05, 1'b0, 1'b1);
    send(32'hE1, 6'h06, 1'b1, 1'b1);
    drain();
`ifdef NOC_RX_PKT_CHECK_EN
    chk("t6_derr", 64'(dest_err), 64'd1);
`else
    chk("t6_derr", 64'(dest_err), 64'd0);
`endif
    chk("t6_pkt", 64'(pkt_count), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/noc_flit_receiver.md
Name: noc_flit_receiver

Overview:
Terminating receiver for one credit-based router-to-router link. It connects to a router output port (data_out/dest_out/is_tail_out/send_out, credit_in) and buffers incoming flits in a FIFO of FLIT_BUFFER_DEPTH entries. Flits are presented as an AXI-stream-like valid/ready stream with tlast derived from is_tail. One credit is returned per flit drained. It is used at mesh edge ports and as a single-clock sink for link-level test benches.

Parameters:
FLIT_WIDTH, 32, flit payload width in bits
DEST_WIDTH, 6, destination field width (TDEST_WIDTH + TID_WIDTH)
FLIT_BUFFER_DEPTH, 8, FIFO entries; must equal the sender's initial credit count; power of two, >= 2
PKT_CNT_WIDTH, 16, width of the delivered-packet counter

Ports:
clk_noc  in  1  link clock; all logic is on this clock
rst_n  in  1  asynchronous active-low reset
data_in  in  FLIT_WIDTH  flit payload from upstream router
dest_in  in  DEST_WIDTH  flit destination
is_tail_in  in  1  flit is the last of its packet
send_in  in  1  flit valid this cycle; no backpressure on this side
credit_out  out  1  one-cycle pulse; returns one buffer slot upstream
m_tvalid  out  1  output flit valid
m_tready  in  1  consumer ready
m_tdata  out  FLIT_WIDTH  output payload
m_tdest  out  DEST_WIDTH  output destination
m_tlast  out  1  output flit is tail
pkt_count  out  PKT_CNT_WIDTH  packets delivered (tail handshakes), wraps
overflow_err  out  1  sticky: flit arrived while full
dest_err  out  1  sticky: dest changed within a packet (see optional feature)

Behaviour:
- Reset (async assert, sync release on clk_noc): FIFO empty; wr/rd pointers 0; credit_out=0; m_tvalid=0; m_tdata/m_tdest/m_tlast=0; pkt_count=0; overflow_err=0; dest_err=0. No credits are issued at reset; the sender starts with FLIT_BUFFER_DEPTH credits.
- Push: on a clk_noc edge with send_in=1, {data_in,dest_in,is_tail_in} are written at wr_ptr and count is incremented. This requires count<DEPTH, or a pop in the same cycle.
- Latency: a flit sampled at edge N drives m_tvalid=1 with its fields after edge N (registered, show-ahead output). Minimum latency is 1 cycle.
- Pop: a handshake occurs when m_tvalid&&m_tready at an edge. The read pointer advances and m_* shows the next entry, or m_tvalid drops to 0 if the FIFO is empty. m_* are stable while m_tvalid=1 and m_tready=0.
- Credit: credit_out=1 for exactly the one cycle after each pop edge, registered. Back-to-back pops give consecutive credit pulses. Credits issued never exceed pops.
- Simultaneous push and pop: count is unchanged. When full, the push is accepted because a slot frees on the same edge.
- Full with push and no pop: the flit is dropped, FIFO contents are unchanged, and overflow_err sets and holds until reset. No credit is generated for the dropped flit.
- Empty: m_tvalid=0 and m_tready is ignored.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- pkt_count increments by 1 on each pop with m_tlast=1 and wraps from 2^PKT_CNT_WIDTH-1 to 0.
- Reset mid-packet: all state clears immediately. Flits in flight are lost. The sender must be reset together with this block.

Optional Feature:
- Macro: NOC_RX_PKT_CHECK_EN.
- Defined: a push-side FSM with states IDLE and IN_PKT, reset to IDLE.
  - IDLE + push with !is_tail: latch dest_in -> IN_PKT.
  - IDLE + push with is_tail: single-flit packet, stay in IDLE.
  - IN_PKT + push with dest_in != latched dest: set dest_err (sticky).
  - IN_PKT + push with is_tail: -> IDLE.
  - Dropped flits (overflow) do not advance the FSM.
- Not defined: no FSM is built and dest_err is tied to 0.

Test Plan:
1. Reset, then 3-flit packet (dest=6'h05; data A0,A1,A2; tail on A2) with m_tready=1 -> m_tvalid 1 cycle after each send; m_tlast only on A2; 3 credit pulses; pkt_count=1.
2. m_tready=0, send 8 flits -> count=8, no credit_out, m_tdata holds flit 0. Then m_tready=1 for 8 cycles -> 8 consecutive credit pulses, data in order.
3. FIFO full (8), 9th send with m_tready=0 -> overflow_err=1, 9th flit absent from output, only 8 credits after drain.
4. FIFO full, send_in=1 and m_tready=1 on the same edge -> flit accepted, count stays 8, overflow_err=0, 1 credit.
5. Set pkt_count to 16'hFFFF via 65535 single-flit packets, send one more tail -> pkt_count=0.
6. With NOC_RX_PKT_CHECK_EN: head dest=6'h05, body dest=6'h06 -> dest_err=1. Without the macro, the same stimulus -> dest_err=0.
